// File: rtl/rob_commit_queue.sv
// In-order commit buffer: allocates up to ENQ_W entries per cycle, takes out-of-order
// completions, retires up to CMT_W completed entries per cycle from the head in program order.
// Latency: enqueue visible in count_out after the edge; writeback-to-commit one cycle.
// Backpressure: all-or-nothing enqueue, acknowledged combinationally against the registered count.
//
// Ports: clk_in/rst_N_in (async active-low), flush_in, enqueue group (enq_count_in,
// enq_payload_in, enq_ack_out, enq_idx_out), writeback group (wb_valid_in, wb_idx_in,
// wb_exc_in), commit group (commit_valid_out, commit_payload_out, exc_valid_out,
// exc_payload_out), status (count_out, full_out, empty_out).
// Optional: define ROB_PARTIAL_FLUSH_EN to add flush_younger_in/flush_idx_in (mispredict flush).
module rob_commit_queue #(
    parameter int DEPTH     = 64,
    parameter int ENQ_W     = 4,
    parameter int CMT_W     = 4,
    parameter int WB_PORTS  = 3,
    parameter int PAYLOAD_W = 64,
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1),
    localparam int ECW      = $clog2(ENQ_W + 1)
) (
    input  logic                          clk_in,
    input  logic                          rst_N_in,
    input  logic                          flush_in,
    input  logic [ECW-1:0]                enq_count_in,
    input  logic [ENQ_W*PAYLOAD_W-1:0]    enq_payload_in,
    output logic                          enq_ack_out,
    output logic [ENQ_W*IDX_W-1:0]        enq_idx_out,
`ifdef ROB_PARTIAL_FLUSH_EN
    input  logic                          flush_younger_in,
    input  logic [IDX_W-1:0]              flush_idx_in,
`endif
    input  logic [WB_PORTS-1:0]           wb_valid_in,
    input  logic [WB_PORTS*IDX_W-1:0]     wb_idx_in,
    input  logic [WB_PORTS-1:0]           wb_exc_in,
    output logic [CMT_W-1:0]              commit_valid_out,
    output logic [CMT_W*PAYLOAD_W-1:0]    commit_payload_out,
    output logic                          exc_valid_out,
    output logic [PAYLOAD_W-1:0]          exc_payload_out,
    output logic [CNT_W-1:0]              count_out,
    output logic                          full_out,
    output logic                          empty_out
);
    localparam int PW = IDX_W + 1;   // pointer width including wrap bit

    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [PW-1:0]        count;
    logic [PW-1:0]        free_slots;
    logic [PW-1:0]        ncmt;
    logic [DEPTH-1:0]     valid;
    logic [DEPTH-1:0]     done;
    logic [DEPTH-1:0]     exc;
    logic [PAYLOAD_W-1:0] payload [DEPTH];
    logic [IDX_W-1:0]     scan_e;
    logic                 scan_go;
    logic                 enq_block;

    assign count      = tail - head;
    assign free_slots = PW'(DEPTH) - count;
    assign count_out  = count;
    assign full_out   = (count == PW'(DEPTH));
    assign empty_out  = (count == '0);

`ifdef ROB_PARTIAL_FLUSH_EN
    logic             part_flush;
    logic [IDX_W-1:0] keep_off;
    logic [PW-1:0]    part_tail;

    assign part_flush = flush_younger_in && !flush_in;
    // Age of the surviving entry relative to head; new tail sits one past it, which
    // keeps the wrap bit consistent with head.
    assign keep_off   = flush_idx_in - head[IDX_W-1:0];
    assign part_tail  = head + {1'b0, keep_off} + PW'(1);
    assign enq_block  = flush_in || flush_younger_in;
`else
    assign enq_block  = flush_in;
`endif

    // Acceptance uses the count at the start of the cycle; slots freed by this
    // cycle's commits only become usable next cycle. An exception flush in the same
    // cycle still acknowledges, but the flush wins and the new entries are dropped.
    assign enq_ack_out = (PW'(enq_count_in) <= free_slots) && !enq_block;

    always_comb begin
        for (int i = 0; i < ENQ_W; i++) begin
            enq_idx_out[i*IDX_W +: IDX_W] = tail[IDX_W-1:0] + IDX_W'(i);
        end
    end

    // Commit scan from registered state: stop at the first slot that is not
    // valid+done, or after reporting a faulting entry.
    always_comb begin
        commit_valid_out   = '0;
        commit_payload_out = '0;
        exc_valid_out      = 1'b0;
        exc_payload_out    = '0;
        ncmt               = '0;
        scan_e             = head[IDX_W-1:0];
        scan_go            = !flush_in;
        for (int k = 0; k < CMT_W; k++) begin
            scan_e = head[IDX_W-1:0] + IDX_W'(k);
            commit_payload_out[k*PAYLOAD_W +: PAYLOAD_W] = payload[scan_e];
            if (scan_go && valid[scan_e] && done[scan_e]) begin
                if (exc[scan_e]) begin
                    exc_valid_out   = 1'b1;
                    exc_payload_out = payload[scan_e];
                    scan_go         = 1'b0;
                end else begin
                    commit_valid_out[k] = 1'b1;
                    ncmt                = ncmt + PW'(1);
                end
            end else begin
                scan_go = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            head  <= '0;
            tail  <= '0;
            valid <= '0;
            done  <= '0;
            exc   <= '0;
        end else if (flush_in || exc_valid_out) begin
            // Older committed slots retire implicitly: the whole buffer empties.
            head  <= '0;
            tail  <= '0;
            valid <= '0;
            done  <= '0;
            exc   <= '0;
        end else begin
            // Later ports overwrite earlier ones on an index collision.
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid_in[p] && valid[wb_idx_in[p*IDX_W +: IDX_W]]) begin
                    done[wb_idx_in[p*IDX_W +: IDX_W]] <= 1'b1;
                    exc[wb_idx_in[p*IDX_W +: IDX_W]]  <= wb_exc_in[p];
                end
            end
            for (int k = 0; k < CMT_W; k++) begin
                if (commit_valid_out[k]) begin
                    valid[head[IDX_W-1:0] + IDX_W'(k)] <= 1'b0;
                end
            end
            head <= head + ncmt;
            if (enq_ack_out) begin
                for (int i = 0; i < ENQ_W; i++) begin
                    if (ECW'(i) < enq_count_in) begin
                        valid[tail[IDX_W-1:0] + IDX_W'(i)] <= 1'b1;
                        done[tail[IDX_W-1:0] + IDX_W'(i)]  <= 1'b0;
                        exc[tail[IDX_W-1:0] + IDX_W'(i)]   <= 1'b0;
                    end
                end
                tail <= tail + PW'(enq_count_in);
            end
`ifdef ROB_PARTIAL_FLUSH_EN
            if (part_flush) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (IDX_W'(IDX_W'(j) - head[IDX_W-1:0]) > keep_off) begin
                        valid[j] <= 1'b0;
                    end
                end
                tail <= part_tail;
            end
`endif
        end
    end

    // Payload storage carries no reset; only valid bits qualify it.
    always_ff @(posedge clk_in) begin
        if (enq_ack_out) begin
            for (int i = 0; i < ENQ_W; i++) begin
                if (ECW'(i) < enq_count_in) begin
                    payload[tail[IDX_W-1:0] + IDX_W'(i)] <= enq_payload_in[i*PAYLOAD_W +: PAYLOAD_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_rob_commit_queue.sv
module tb_rob_commit_queue;
    localparam int DEPTH = 8;
    localparam int ENQ_W = 4;
    localparam int CMT_W = 4;
    localparam int WBP   = 3;
    localparam int PLW   = 16;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;
    localparam int ECW   = 3;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   flush = 1'b0;
    logic [ECW-1:0]         enq_count = '0;
    logic [ENQ_W*PLW-1:0]   enq_payload = '0;
    logic                   enq_ack;
    logic [ENQ_W*IDX_W-1:0] enq_idx;
    logic [WBP-1:0]         wb_valid = '0;
    logic [WBP*IDX_W-1:0]   wb_idx = '0;
    logic [WBP-1:0]         wb_exc = '0;
    logic [CMT_W-1:0]       commit_valid;
    logic [CMT_W*PLW-1:0]   commit_payload;
    logic                   exc_valid;
    logic [PLW-1:0]         exc_payload;
    logic [CNT_W-1:0]       count;
    logic                   full;
    logic                   empty;
    logic                   flush_younger = 1'b0;
    logic [IDX_W-1:0]       flush_idx = '0;

    rob_commit_queue #(
        .DEPTH(DEPTH), .ENQ_W(ENQ_W), .CMT_W(CMT_W), .WB_PORTS(WBP), .PAYLOAD_W(PLW)
    ) dut (
        .clk_in(clk), .rst_N_in(rst_n), .flush_in(flush),
        .enq_count_in(enq_count), .enq_payload_in(enq_payload),
        .enq_ack_out(enq_ack), .enq_idx_out(enq_idx),
`ifdef ROB_PARTIAL_FLUSH_EN
        .flush_younger_in(flush_younger), .flush_idx_in(flush_idx),
`endif
        .wb_valid_in(wb_valid), .wb_idx_in(wb_idx), .wb_exc_in(wb_exc),
        .commit_valid_out(commit_valid), .commit_payload_out(commit_payload),
        .exc_valid_out(exc_valid), .exc_payload_out(exc_payload),
        .count_out(count), .full_out(full), .empty_out(empty)
    );

    always #5 clk = ~clk;

    // Reference model: program-ordered list of live entries.
    typedef struct {
        logic [PLW-1:0] pl;
        int             idx;
        bit             done;
        bit             exc;
    } ent_t;

    typedef struct {
        bit                     ack;
        logic [ENQ_W*IDX_W-1:0] idxs;
        int                     cnt;
        bit                     full;
        bit                     empty;
        logic [CMT_W-1:0]       mask;
        bit                     exc;
    } cyc_t;

    ent_t           rob[$];
    int             tail_pos = 0;
    logic [PLW-1:0] pl_ctr = 16'h1000;
    logic [PLW-1:0] last_pl [ENQ_W];
    bit             pf = 1'b0;
    int             pf_idx = 0;

    cyc_t           cyc_q[$];
    logic [PLW-1:0] cmt_q[$];
    logic [PLW-1:0] exc_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Drive one cycle of stimulus, record what the DUT must show this cycle,
    // advance the model, and return just after the next rising edge.
    task automatic step(input bit fl, input int n, input logic [WBP-1:0] wv,
                        input logic [WBP*IDX_W-1:0] wi, input logic [WBP-1:0] we);
        cyc_t c;
        int   ncm;
        bit   go;
        int   sz;
        flush         = fl;
        enq_count     = ECW'(n);
        wb_valid      = wv;
        wb_idx        = wi;
        wb_exc        = we;
        flush_younger = pf;
        flush_idx     = IDX_W'(pf_idx);
        for (int i = 0; i < ENQ_W; i++) enq_payload[i*PLW +: PLW] = pl_ctr + PLW'(i);
        pl_ctr = pl_ctr + PLW'(ENQ_W);

        sz      = rob.size();
        c.cnt   = sz;
        c.full  = (sz == DEPTH);
        c.empty = (sz == 0);
        c.ack   = (n <= DEPTH - sz) && !fl && !pf;
        for (int i = 0; i < ENQ_W; i++) c.idxs[i*IDX_W +: IDX_W] = IDX_W'((tail_pos + i) % DEPTH);
        c.mask = '0;
        c.exc  = 1'b0;
        ncm    = 0;
        go     = !fl;
        for (int k = 0; k < CMT_W; k++) begin
            if (go && k < sz && rob[k].done) begin
                if (rob[k].exc) begin
                    c.exc = 1'b1;
                    exc_q.push_back(rob[k].pl);
                    go = 1'b0;
                end else begin
                    c.mask[k] = 1'b1;
                    cmt_q.push_back(rob[k].pl);
                    ncm++;
                end
            end else begin
                go = 1'b0;
            end
        end
        cyc_q.push_back(c);

        if (fl || c.exc) begin
            rob.delete();
            tail_pos = 0;
        end else begin
            for (int p = 0; p < WBP; p++) begin
                if (wv[p]) begin
                    for (int j = 0; j < rob.size(); j++) begin
                        if (rob[j].idx == int'(wi[p*IDX_W +: IDX_W])) begin
                            rob[j].done = 1'b1;
                            rob[j].exc  = we[p];
                        end
                    end
                end
            end
            if (pf) begin
                int keep;
                keep = rob.size();
                for (int j = 0; j < rob.size(); j++) if (rob[j].idx == pf_idx) keep = j + 1;
                while (rob.size() > keep) void'(rob.pop_back());
                tail_pos = (pf_idx + 1) % DEPTH;
            end
            for (int k = 0; k < ncm; k++) void'(rob.pop_front());
            if (c.ack) begin
                for (int i = 0; i < n; i++) begin
                    ent_t e;
                    e.pl   = enq_payload[i*PLW +: PLW];
                    e.idx  = (tail_pos + i) % DEPTH;
                    e.done = 1'b0;
                    e.exc  = 1'b0;
                    rob.push_back(e);
                    last_pl[i] = e.pl;
                end
                tail_pos = (tail_pos + n) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 0, '0, '0, '0);
    endtask

    // Monitor: compares per-cycle outputs and pops commit/exception streams
    // whenever the DUT presents them.
    cyc_t mc;
    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            mc = cyc_q.pop_front();
            chk("enq_ack", enq_ack, mc.ack);
            chk("enq_idx", enq_idx, mc.idxs);
            chk("count", count, mc.cnt);
            chk("full", full, mc.full);
            chk("empty", empty, mc.empty);
            chk("commit_mask", commit_valid, mc.mask);
            chk("exc_valid", exc_valid, mc.exc);
        end
        for (int k = 0; k < CMT_W; k++) begin
            if (commit_valid[k] === 1'b1) begin
                if (cmt_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL commit_unexpected: slot %0d payload %0h, expected no commit", k,
                             commit_payload[k*PLW +: PLW]);
                end else begin
                    chk("commit_payload", commit_payload[k*PLW +: PLW], cmt_q.pop_front());
                end
            end
        end
        if (exc_valid === 1'b1) begin
            if (exc_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL exc_unexpected: payload %0h, expected no exception", exc_payload);
            end else begin
                chk("exc_payload", exc_payload, exc_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not reach its end, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit             fl;
        int             n;
        int             r;
        logic [WBP-1:0]       wv;
        logic [WBP*IDX_W-1:0] wi;
        logic [WBP-1:0]       we;

        #22 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_count", count, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_commit", commit_valid, 0);
        chk("reset_exc", exc_valid, 0);

        // Enqueue 4 into an empty buffer.
        step(1'b0, 4, '0, '0, '0);
        chk("tp1_count4", count, 4);
        // Writebacks 2,0,1,3 on consecutive cycles.
        step(1'b0, 0, 3'b001, 9'd2, '0);
        step(1'b0, 0, 3'b001, 9'd0, '0);
        step(1'b0, 0, 3'b001, 9'd1, '0);
        step(1'b0, 0, 3'b001, 9'd3, '0);
        idle(2);
        chk("tp2_empty", empty, 1);

        // Fill to 8, then request while committing at full.
        step(1'b0, 4, '0, '0, '0);
        step(1'b0, 4, '0, '0, '0);
        chk("tp3_full", full, 1);
        step(1'b0, 0, 3'b011, {3'd0, 3'd5, 3'd4}, '0);
        step(1'b0, 1, '0, '0, '0);
        step(1'b0, 2, '0, '0, '0);
        step(1'b0, 0, 3'b111, {3'd0, 3'd7, 3'd6}, '0);
        step(1'b0, 0, 3'b111, {3'd2, 3'd1, 3'd0}, '0);
        step(1'b0, 0, 3'b111, {3'd5, 3'd4, 3'd3}, '0);
        idle(3);

        // Faulting entry behind two completed ones.
        step(1'b1, 0, '0, '0, '0);
        step(1'b0, 4, '0, '0, '0);
        step(1'b0, 0, 3'b111, {3'd2, 3'd1, 3'd0}, 3'b100);
        chk("tp4_mask", commit_valid, 4'b0011);
        chk("tp4_exc", exc_valid, 1);
        chk("tp4_exc_pl", exc_payload, last_pl[2]);
        step(1'b0, 0, 3'b001, 9'd3, '0);
        chk("tp4_count0", count, 0);

        // Flush together with enqueue and writeback.
        step(1'b0, 2, '0, '0, '0);
        step(1'b0, 0, 3'b001, 9'd0, '0);
        step(1'b1, 3, 3'b010, {3'd0, 3'd1, 3'd0}, '0);
        chk("tp5_count0", count, 0);

`ifdef ROB_PARTIAL_FLUSH_EN
        step(1'b0, 4, '0, '0, '0);
        step(1'b0, 2, '0, '0, '0);
        pf     = 1'b1;
        pf_idx = 2;
        step(1'b0, 0, '0, '0, '0);
        pf     = 1'b0;
        chk("tp6_count3", count, 3);
        chk("tp6_next_idx", enq_idx[IDX_W-1:0], 3);
        step(1'b1, 0, '0, '0, '0);
`endif

        // Randomized traffic with a mid-cycle asynchronous reset halfway.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc == 1000) begin
                flush     = 1'b0;
                enq_count = '0;
                wb_valid  = '0;
                #1 rst_n  = 1'b0;
                #1;
                chk("midreset_count", count, 0);
                chk("midreset_empty", empty, 1);
                chk("midreset_commit", commit_valid, 0);
                chk("midreset_exc", exc_valid, 0);
                rob.delete();
                tail_pos = 0;
                #1 rst_n = 1'b1;
            end
            fl = ($urandom_range(0, 49) == 0);
            n  = $urandom_range(0, ENQ_W);
            for (int p = 0; p < WBP; p++) begin
                wv[p] = ($urandom_range(0, 2) != 0);
                if (rob.size() > 0 && $urandom_range(0, 3) != 0) begin
                    r = $urandom_range(0, rob.size() - 1);
                    wi[p*IDX_W +: IDX_W] = IDX_W'(rob[r].idx);
                end else begin
                    wi[p*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, DEPTH - 1));
                end
                we[p] = ($urandom_range(0, 24) == 0);
            end
            step(fl, n, wv, wi, we);
        end

        // Drain: complete everything still live.
        for (int t = 0; t < 200 && rob.size() > 0; t++) begin
            wv = '0;
            wi = '0;
            for (int p = 0; p < WBP; p++) begin
                if (p < rob.size()) begin
                    wv[p] = 1'b1;
                    wi[p*IDX_W +: IDX_W] = IDX_W'(rob[p].idx);
                end
            end
            step(1'b0, 0, wv, wi, '0);
        end
        idle(2);
        chk("drain_count", count, 0);
        chk("cmt_stream_left", cmt_q.size(), 0);
        chk("exc_stream_left", exc_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
